// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// I2C target: oversamples SCL/SDA, answers a fixed 7-bit address, and moves
// bus bytes into an RX FIFO (writes) or out of a TX FIFO (reads). SDA is open-drain.
module i2c_target #(
  parameter int I2C_DATA_WIDTH = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_FIFO_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLV_ADDR = 7'h50
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scl_in,
  input  logic                      sda_in,
  output logic                      sda_oe,
  output logic                      fifo_wr_en,
  output logic [I2C_FIFO_WIDTH-1:0] fifo_wr_data,
  input  logic                      f_full,
  output logic                      fifo_read_en,
  input  logic [I2C_FIFO_WIDTH-1:0] fifo_read_data,
  input  logic                      f_empty,
  output logic                      busy,
  output logic                      rw,
  output logic                      rx_overflow,
  output logic                      tx_underrun
);

  localparam logic [3:0] BITS = 4'(I2C_DATA_WIDTH);
  localparam logic [3:0] LAST = BITS - 4'd1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_LOAD,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } state_t;

  // Bit 1 is SCL, bit 0 is SDA; idle bus level is high, so reset to 1.
  logic [1:0] sync1_reg, sync2_reg, hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
      hist_reg  <= 2'b11;
    end else begin
      sync1_reg <= {scl_in, sda_in};
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  assign scl_s     = sync2_reg[1];
  assign sda_s     = sync2_reg[0];
  assign scl_d     = hist_reg[1];
  assign sda_d     = hist_reg[0];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign sda_rise  = sda_s & ~sda_d;
  assign sda_fall  = ~sda_s & sda_d;
  assign start_det = sda_fall & scl_s & scl_d;
  assign stop_det  = sda_rise & scl_s & scl_d;

  state_t                    state_reg, state_next;
  logic [3:0]                bit_cnt_reg, bit_cnt_next;
  logic [I2C_DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                      sda_oe_reg, sda_oe_next;
  logic                      busy_reg, busy_next;
  logic                      rw_reg, rw_next;
  logic                      popped_reg, popped_next;
  logic                      load_phase_reg, load_phase_next;
  logic                      acked_reg, acked_next;
  logic                      wr_en_reg, wr_en_next;
  logic [I2C_FIFO_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic                      rd_en_reg, rd_en_next;
  logic                      rx_ovf_reg, rx_ovf_next;
  logic                      tx_und_reg, tx_und_next;

  logic [I2C_DATA_WIDTH-1:0] shifted_in;
  logic [I2C_DATA_WIDTH-1:0] load_byte;

  assign shifted_in = {shift_reg[I2C_DATA_WIDTH-2:0], sda_s};
  assign load_byte  = popped_reg ? fifo_read_data : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      sda_oe_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      rw_reg         <= 1'b0;
      popped_reg     <= 1'b0;
      load_phase_reg <= 1'b0;
      acked_reg      <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= '0;
      rd_en_reg      <= 1'b0;
      rx_ovf_reg     <= 1'b0;
      tx_und_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      sda_oe_reg     <= sda_oe_next;
      busy_reg       <= busy_next;
      rw_reg         <= rw_next;
      popped_reg     <= popped_next;
      load_phase_reg <= load_phase_next;
      acked_reg      <= acked_next;
      wr_en_reg      <= wr_en_next;
      wr_data_reg    <= wr_data_next;
      rd_en_reg      <= rd_en_next;
      rx_ovf_reg     <= rx_ovf_next;
      tx_und_reg     <= tx_und_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    sda_oe_next     = sda_oe_reg;
    busy_next       = busy_reg;
    rw_next         = rw_reg;
    popped_next     = popped_reg;
    load_phase_next = load_phase_reg;
    acked_next      = acked_reg;
    wr_data_next    = wr_data_reg;
    wr_en_next      = 1'b0;
    rd_en_next      = 1'b0;
    rx_ovf_next     = 1'b0;
    tx_und_next     = 1'b0;

    // Bus conditions override any byte in flight; a partial byte is dropped.
    if (start_det) begin
      state_next   = ST_ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
    end else if (stop_det) begin
      state_next  = ST_IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          sda_oe_next = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise && bit_cnt_reg != BITS) begin
            shift_next   = shifted_in;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == LAST) begin
              if (shifted_in[I2C_DATA_WIDTH-1:1] == SLV_ADDR) begin
                rw_next = shifted_in[0];
              end else begin
                state_next = ST_WAIT_STOP;
                busy_next  = 1'b0;
              end
            end
          end else if (scl_fall && bit_cnt_reg == BITS) begin
            sda_oe_next = 1'b1;
            busy_next   = 1'b1;
            state_next  = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            if (!rw_reg) begin
              state_next   = ST_RX_BYTE;
              bit_cnt_next = '0;
            end else begin
              rd_en_next      = !f_empty;
              popped_next     = !f_empty;
              load_phase_next = 1'b0;
              state_next      = ST_TX_LOAD;
            end
          end
        end
        ST_RX_BYTE: begin
          if (scl_rise && bit_cnt_reg != BITS) begin
            shift_next   = shifted_in;
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == BITS) begin
            if (!f_full) begin
              wr_en_next   = 1'b1;
              wr_data_next = shift_reg;
              sda_oe_next  = 1'b1;
            end else begin
              rx_ovf_next = 1'b1;
            end
            state_next = ST_RX_ACK;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = '0;
            state_next   = ST_RX_BYTE;
          end
        end
        ST_TX_LOAD: begin
          // First cycle is the pop itself; FIFO data is valid on the second.
          if (!load_phase_reg) begin
            load_phase_next = 1'b1;
          end else begin
            shift_next   = load_byte;
            tx_und_next  = !popped_reg;
            sda_oe_next  = ~load_byte[I2C_DATA_WIDTH-1];
            bit_cnt_next = '0;
            state_next   = ST_TX_BYTE;
          end
        end
        ST_TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_reg == LAST) begin
              sda_oe_next = 1'b0;
              acked_next  = 1'b0;
              state_next  = ST_TX_ACK;
            end else begin
              shift_next   = {shift_reg[I2C_DATA_WIDTH-2:0], 1'b1};
              sda_oe_next  = ~shift_reg[I2C_DATA_WIDTH-2];
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_next = ST_WAIT_STOP;
            else       acked_next = 1'b1;
          end else if (scl_fall && acked_reg) begin
            acked_next      = 1'b0;
            rd_en_next      = !f_empty;
            popped_next     = !f_empty;
            load_phase_next = 1'b0;
            state_next      = ST_TX_LOAD;
          end
        end
        ST_WAIT_STOP: begin
          sda_oe_next = 1'b0;
        end
        default: begin
          state_next  = ST_IDLE;
          sda_oe_next = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe       = sda_oe_reg;
  assign fifo_wr_en   = wr_en_reg;
  assign fifo_wr_data = wr_data_reg;
  assign fifo_read_en = rd_en_reg;
  assign busy         = busy_reg;
  assign rw           = rw_reg;
  assign rx_overflow  = rx_ovf_reg;
  assign tx_underrun  = tx_und_reg;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Bench for i2c_target: an I2C initiator model drives the pins, FIFOs are modelled,
// and each transaction is scored against expectations from a table or a byte-level model.
module tb_i2c_target;

  localparam int Q = 8;                  // quarter SCL period in clk cycles
  localparam logic [6:0] TARGET = 7'h50;

  logic       clk;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_oe;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       f_full;
  logic       fifo_read_en;
  logic [7:0] fifo_read_data = 8'h00;
  logic       f_empty;
  logic       busy, rw, rx_overflow, tx_underrun;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scl_in         (scl_m),
    .sda_in         (sda_bus),
    .sda_oe         (sda_oe),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .f_full         (f_full),
    .fifo_read_en   (fifo_read_en),
    .fifo_read_data (fifo_read_data),
    .f_empty        (f_empty),
    .busy           (busy),
    .rw             (rw),
    .rx_overflow    (rx_overflow),
    .tx_underrun    (tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models and event monitors, all sampled on the falling clock edge.
  logic [7:0] tx_mem [256];
  int         tx_wr_ptr = 0;
  int         tx_rd_ptr = 0;
  logic [7:0] wr_log [$];
  int         rd_pulses = 0, ovf_cnt = 0, und_cnt = 0, oe_cnt = 0, busy_falls = 0;
  logic       busy_q = 1'b0;

  assign f_empty = (tx_rd_ptr == tx_wr_ptr);

  always @(negedge clk) begin
    if (fifo_wr_en) wr_log.push_back(fifo_wr_data);
    if (fifo_read_en) rd_pulses <= rd_pulses + 1;
    if (fifo_read_en && tx_rd_ptr != tx_wr_ptr) begin
      fifo_read_data <= tx_mem[tx_rd_ptr[7:0]];
      tx_rd_ptr      <= tx_rd_ptr + 1;
    end
    if (rx_overflow) ovf_cnt <= ovf_cnt + 1;
    if (tx_underrun) und_cnt <= und_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    busy_q <= busy;
    if (busy_q && !busy) busy_falls <= busy_falls + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit-level initiator; every task leaves SCL low except start-from-idle/stop.
  task automatic i2c_start();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(2 * Q); scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); b = sda_bus;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  // acked = 1 when the target pulled SDA low on the ninth clock.
  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  typedef struct {
    logic [7:0]  addr;
    int          n;
    logic [31:0] data;       // write bytes, or TX FIFO preload for reads (byte 0 lowest)
    int          tx_n;
    logic [3:0]  full_mask;  // f_full held high during data byte i
    logic [4:0]  exp_acks;   // bit 0 address, bit i+1 data byte i
    int          exp_push;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          exp_pops;
    int          exp_ovf;
    int          exp_und;
  } txn_t;

  // Byte-level reference: what a target at TARGET with the given FIFOs must do.
  function automatic txn_t model(input txn_t t);
    txn_t r;
    logic match;
    r = t;
    match = (t.addr[7:1] == TARGET);
    r.exp_acks = '0; r.exp_push = 0; r.exp_wdata = '0; r.exp_rdata = '0;
    r.exp_pops = 0; r.exp_ovf = 0; r.exp_und = 0;
    r.exp_acks[0] = match;
    for (int i = 0; i < t.n; i++) begin
      if (!t.addr[0]) begin
        if (match && !t.full_mask[i]) begin
          r.exp_acks[i+1] = 1'b1;
          r.exp_wdata[8*r.exp_push +: 8] = t.data[8*i +: 8];
          r.exp_push++;
        end else if (match) begin
          r.exp_ovf++;
        end
      end else begin
        if (match && i < t.tx_n) begin
          r.exp_rdata[8*i +: 8] = t.data[8*i +: 8];
          r.exp_pops++;
        end else begin
          r.exp_rdata[8*i +: 8] = 8'hFF;
          if (match) r.exp_und++;
        end
      end
    end
    return r;
  endfunction

  task automatic run_txn(input txn_t t, input string tag);
    int          wr0, rd0, ovf0, und0, npush;
    logic [4:0]  acks, mask;
    logic [31:0] rdata, wdata;
    logic [7:0]  b;
    logic        a, match, busy_mid;
    for (int k = 0; k < t.tx_n; k++) tx_mem[8'(tx_rd_ptr + k)] = t.data[8*k +: 8];
    tx_wr_ptr = tx_rd_ptr + t.tx_n;
    wr0 = wr_log.size(); rd0 = rd_pulses; ovf0 = ovf_cnt; und0 = und_cnt;
    acks = '0; rdata = '0; wdata = '0;
    match = (t.addr[7:1] == TARGET);
    i2c_start();
    write_byte(t.addr, a);
    acks[0] = a;
    busy_mid = busy;
    for (int i = 0; i < t.n; i++) begin
      if (!t.addr[0]) begin
        f_full = t.full_mask[i];
        write_byte(t.data[8*i +: 8], a);
        acks[i+1] = a;
        f_full = 1'b0;
      end else begin
        read_byte(b);
        rdata[8*i +: 8] = b;
        write_bit(i == t.n - 1);
      end
    end
    i2c_stop();
    wait_clk(4);
    npush = wr_log.size() - wr0;
    for (int k = 0; k < npush && k < 4; k++) wdata[8*k +: 8] = wr_log[wr0 + k];
    mask = t.addr[0] ? 5'b00001 : 5'((6'd1 << (t.n + 1)) - 6'd1);
    check({tag, ".acks"}, acks & mask, t.exp_acks & mask);
    check({tag, ".pushes"}, npush, t.exp_push);
    check({tag, ".wdata"}, wdata, t.exp_wdata);
    check({tag, ".pops"}, rd_pulses - rd0, t.exp_pops);
    check({tag, ".overflow"}, ovf_cnt - ovf0, t.exp_ovf);
    check({tag, ".underrun"}, und_cnt - und0, t.exp_und);
    check({tag, ".busy_mid"}, busy_mid, match);
    check({tag, ".busy_end"}, busy, 1'b0);
    if (t.addr[0]) check({tag, ".rdata"}, rdata, t.exp_rdata);
    if (match) check({tag, ".rw"}, rw, t.addr[0]);
    $display("txn %s addr=%02h n=%0d acks=%b pushes=%0d wdata=%08h rdata=%08h", tag, t.addr,
             t.n, acks & mask, npush, wdata, rdata);
  endtask

  txn_t vec [6];
  txn_t rt;

  initial begin
    logic       a;
    logic [7:0] b;
    int         oe0, falls0, wr0, rd0;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; f_full = 1'b0;
    wait_clk(5);
    check("rst.sda_oe", sda_oe, 1'b0);
    check("rst.fifo_wr_en", fifo_wr_en, 1'b0);
    check("rst.fifo_wr_data", fifo_wr_data, 8'h00);
    check("rst.fifo_read_en", fifo_read_en, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.rw", rw, 1'b0);
    check("rst.rx_overflow", rx_overflow, 1'b0);
    check("rst.tx_underrun", tx_underrun, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);

    //          addr   n  data          tx full     acks      push wdata   rdata       pop ovf und
    vec[0] = '{8'hA0, 2, 32'h0000_3412, 0, 4'b0000, 5'b00111, 2, 32'h3412, 32'h0,      0,  0,  0};
    vec[1] = '{8'hA1, 2, 32'h0000_3CA5, 2, 4'b0000, 5'b00001, 0, 32'h0,    32'h3CA5,   2,  0,  0};
    vec[2] = '{8'h90, 1, 32'h0000_0055, 0, 4'b0000, 5'b00000, 0, 32'h0,    32'h0,      0,  0,  0};
    vec[3] = '{8'hA0, 2, 32'h0000_2211, 0, 4'b0010, 5'b00011, 1, 32'h11,   32'h0,      0,  1,  0};
    vec[4] = '{8'hA1, 2, 32'h0000_005A, 1, 4'b0000, 5'b00001, 0, 32'h0,    32'hFF5A,   1,  0,  1};
    vec[5] = '{8'hA3, 1, 32'h0000_0099, 1, 4'b0000, 5'b00000, 0, 32'h0,    32'hFF,     0,  0,  0};

    for (int i = 0; i < 6; i++) begin
      oe0 = oe_cnt;
      run_txn(vec[i], $sformatf("vec%0d", i));
      if (vec[i].addr[7:1] != TARGET) check($sformatf("vec%0d.oe_quiet", i), oe_cnt - oe0, 0);
    end

    // Repeated START: write then read without an intervening STOP.
    tx_mem[8'(tx_rd_ptr)] = 8'h77;
    tx_wr_ptr = tx_rd_ptr + 1;
    wr0 = wr_log.size(); rd0 = rd_pulses;
    i2c_start();
    write_byte(8'hA0, a); check("rs.addr_w_ack", a, 1'b1);
    write_byte(8'h01, a); check("rs.data_ack", a, 1'b1);
    check("rs.rw_write", rw, 1'b0);
    check("rs.busy_write", busy, 1'b1);
    falls0 = busy_falls;
    i2c_start();
    write_byte(8'hA1, a); check("rs.addr_r_ack", a, 1'b1);
    check("rs.rw_read", rw, 1'b1);
    read_byte(b);
    write_bit(1'b1);
    check("rs.busy_held", busy_falls - falls0, 0);
    i2c_stop();
    wait_clk(4);
    check("rs.rdata", b, 8'h77);
    check("rs.pops", rd_pulses - rd0, 1);
    check("rs.pushes", wr_log.size() - wr0, 1);
    check("rs.push_byte", wr_log[wr0], 8'h01);
    check("rs.busy_end", busy, 1'b0);
    $display("txn rs write=01 read=%02h rw=%b", b, rw);

    // Reset while the target is ACKing its address: SDA must release at once.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(vec[0].addr[i]);
    wait_clk(Q);
    check("rstmid.ack_driven", sda_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rstmid.sda_released", sda_oe, 1'b0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    wait_clk(3);
    check("rstmid.busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);
    $display("txn rstmid sda_oe=%b busy=%b", sda_oe, busy);
    rt = '{8'hA0, 1, 32'h5C, 0, 4'b0000, 5'b00011, 1, 32'h5C, 32'h0, 0, 0, 0};
    run_txn(rt, "after_rst");

    // Randomized transactions scored by the byte-level model.
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0:       rt.addr = 8'hA0;
        1:       rt.addr = 8'hA1;
        2:       rt.addr = {TARGET, 1'b0} ^ 8'($urandom_range(0, 255) & 8'hFE);
        default: rt.addr = 8'($urandom_range(0, 255));
      endcase
      rt.n         = $urandom_range(1, 4);
      rt.data      = $urandom;
      rt.tx_n      = $urandom_range(0, 4);
      rt.full_mask = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rt = model(rt);
      oe0 = oe_cnt;
      run_txn(rt, $sformatf("rnd%0d", i));
      if (rt.addr[7:1] != TARGET) check($sformatf("rnd%0d.oe_quiet", i), oe_cnt - oe0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) for the far end of the bus driven by the team's I2C controller path. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address, and moves data through FIFOs: bytes written by the bus initiator are pushed into an RX FIFO, and bytes requested by the initiator are popped from a TX FIFO. Drives SDA open-drain only (pull-low enable); never drives SCL, so there is no clock stretching.

## Interface
- I2C_DATA_WIDTH, 8, bus byte width; fixed at 8.
- I2C_ADDR_WIDTH, 7, target address width.
- I2C_FIFO_WIDTH, 8, FIFO data width; must equal I2C_DATA_WIDTH.
- SLV_ADDR, 7'h50, this target's bus address.

Ports:
- clk  in  1  system clock. Frequency must be ≥ 10× SCL.
- rst_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 pulls SDA low; 0 releases SDA.
- fifo_wr_en  out  1  RX FIFO push, 1-cycle pulse.
- fifo_wr_data  out  I2C_FIFO_WIDTH  RX byte; valid with fifo_wr_en.
- f_full  in  1  RX FIFO full.
- fifo_read_en  out  1  TX FIFO pop, 1-cycle pulse.
- fifo_read_data  in  I2C_FIFO_WIDTH  TX byte; valid 1 cycle after fifo_read_en.
- f_empty  in  1  TX FIFO empty.
- busy  out  1  high from an addressed START until STOP or mismatch.
- rw  out  1  R/W bit of the current addressed transfer.
- rx_overflow  out  1  1-cycle pulse when an RX byte is NACKed because f_full is high.
- tx_underrun  out  1  1-cycle pulse when a TX byte is needed but f_empty is high.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer plus a history register. Edge events (scl_rise, scl_fall, sda_rise, sda_fall) are single-cycle strobes on the synchronized signals.
- START = sda_fall while SCL is high. STOP = sda_rise while SCL is high. These are checked in every state and take priority over all other activity:
  - START clears the bit counter, releases SDA, and goes to ADDR (this covers repeated START).
  - STOP releases SDA and goes to IDLE.
- Bits are sampled MSB-first on scl_rise. SDA is changed only on scl_fall.
- States:
  - IDLE: SDA released, busy = 0.
  - ADDR: shift in 8 bits. On the 8th scl_rise, compare bits [7:1] with SLV_ADDR and latch bit 0 into rw.
    - Match: on the next scl_fall assert sda_oe (ACK), set busy, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP with SDA released.
  - ADDR_ACK: on scl_fall, release SDA.
    - rw = 0: go to RX_BYTE.
    - rw = 1: pulse fifo_read_en if !f_empty, then go to TX_LOAD.
  - RX_BYTE: shift in 8 bits. On the scl_fall after the 8th bit:
    - !f_full: pulse fifo_wr_en with the byte and assert sda_oe (ACK).
    - f_full: no push, SDA released (NACK), pulse rx_overflow.
    - In both cases go to RX_ACK.
  - RX_ACK: on scl_fall, release SDA and return to RX_BYTE.
  - TX_LOAD: one cycle after fifo_read_en, load fifo_read_data into the shift register. On underrun, load 8'hFF and pulse tx_underrun. Drive sda_oe = ~MSB and go to TX_BYTE.
  - TX_BYTE: on each scl_fall, shift and drive the next bit. On the scl_fall after the 8th bit, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on scl_rise.
    - 0 (ACK): on scl_fall, pop the next byte and go to TX_LOAD.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released. Wait for START or STOP.
- busy clears on STOP or on address mismatch. rw holds its value until the next address match.

## Timing
- Reset values: sda_oe = 0, fifo_wr_en = 0, fifo_wr_data = 0, fifo_read_en = 0, busy = 0, rw = 0, rx_overflow = 0, tx_underrun = 0, state = IDLE.
- Asserting rst_n mid-transfer releases SDA immediately, without waiting for a clock edge.
- Pin-to-event latency: 3 clk (2 synchronizer stages plus the edge register).
- sda_oe changes on the same cycle as the scl_fall strobe.
- Exception: the first TX bit after a load is driven 2 cycles after the scl_fall strobe (pop cycle, then load cycle).
- fifo_wr_en and fifo_read_en are exactly 1 cycle wide. There is at most one pulse per byte.
- A START or STOP strobe in the same cycle as an SCL edge strobe takes priority; the partial byte is discarded and nothing is pushed.

## Test plan
- Write: START, byte 0xA0, bytes 0x12 then 0x34, STOP → ACK on all three bytes; fifo_wr_en pulses twice with 0x12 then 0x34; busy rises after the address byte and falls after STOP.
- Read: TX FIFO holds 0xA5, 0x3C; START, byte 0xA1, initiator ACKs the first byte and NACKs the second, then STOP → SDA carries 0xA5 then 0x3C; exactly 2 fifo_read_en pulses; rw = 1.
- Address mismatch: START, byte 0x90, 0x55, STOP → sda_oe stays 0 throughout; no FIFO activity; busy stays 0.
- RX full: f_full = 1 during the second data byte → that byte is NACKed, rx_overflow pulses once, only the first byte is pushed.
- Repeated START: write 0xA0, 0x01, then repeated START with 0xA1, read 1 byte, NACK, STOP → rw goes 0→1 and busy stays high across the repeated START.
- Reset while sda_oe = 1 (during an ACK) → sda_oe = 0 immediately; the next START with 0xA0 is ACKed normally.
